// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, register-file constants and ALU opcodes for the ID/EX operand stage.
// Also holds the forwarding-source select type used by the operand muxes.
package id_ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 5;
    localparam int CTRL_W_DEF = 4;

    // X31 reads as zero and is never a forwarding target
    localparam int XZR_IDX = 31;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd.sv
// Priority forwarding mux for one ALU source operand.
// EX/MEM wins over MEM/WB; a source of XZR always uses the register-file value.
module operand_forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exmem_wr,
    input  logic [REG_W-1:0]  exmem_rw,
    input  logic [DATA_W-1:0] exmem_busw,
    input  logic              memwb_wr,
    input  logic [REG_W-1:0]  memwb_rw,
    input  logic [DATA_W-1:0] memwb_busw,
    output logic [DATA_W-1:0] fwd
);

    localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

    logic     src_is_xzr;
    logic     hit_exmem;
    logic     hit_memwb;
    fwd_sel_e sel;

    assign src_is_xzr = (src == XZR);
    assign hit_exmem  = exmem_wr && (exmem_rw == src) && !src_is_xzr;
    assign hit_memwb  = memwb_wr && (memwb_rw == src) && !src_is_xzr;

    always_comb begin
        sel = FWD_REG;
        if (hit_exmem) begin
            sel = FWD_EXMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd = reg_val;
        case (sel)
            FWD_EXMEM: fwd = exmem_busw;
            FWD_MEMWB: fwd = memwb_busw;
            default:   fwd = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding in front of the 64-bit ALU.
// Holds on stall (refreshing sources retired by MEM/WB), bubbles on flush.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              Clk,
    input  logic              ResetL,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [DATA_W-1:0] RegA,
    input  logic [DATA_W-1:0] RegB,
    input  logic [DATA_W-1:0] Imm,
    input  logic [REG_W-1:0]  RA,
    input  logic [REG_W-1:0]  RB,
    input  logic [REG_W-1:0]  RW,
    input  logic              ALUSrc,
    input  logic [CTRL_W-1:0] ALUCtrlIn,
    input  logic              RegWrIn,
    input  logic              ExMemRegWr,
    input  logic [REG_W-1:0]  ExMemRW,
    input  logic [DATA_W-1:0] ExMemBusW,
    input  logic              MemWbRegWr,
    input  logic [REG_W-1:0]  MemWbRW,
    input  logic [DATA_W-1:0] MemWbBusW,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_W-1:0]  RWOut,
    output logic              RegWrOut,
    output logic              OutValid
);

    localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

    logic [DATA_W-1:0] rega_q;
    logic [DATA_W-1:0] regb_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_W-1:0]  ra_q;
    logic [REG_W-1:0]  rb_q;
    logic [REG_W-1:0]  rw_q;
    logic              alusrc_q;
    logic [CTRL_W-1:0] aluctrl_q;
    logic              regwr_q;
    logic              valid_q;

    logic              memwb_live;
    logic              refresh_a;
    logic              refresh_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // A value retiring from MEM/WB while we are stalled would otherwise be lost
    assign memwb_live = MemWbRegWr && (MemWbRW != XZR);
    assign refresh_a  = memwb_live && (MemWbRW == ra_q);
    assign refresh_b  = memwb_live && (MemWbRW == rb_q);

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            rega_q    <= '0;
            regb_q    <= '0;
            imm_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            alusrc_q  <= 1'b0;
            aluctrl_q <= '0;
            regwr_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (Flush) begin
            rega_q    <= '0;
            regb_q    <= '0;
            imm_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            alusrc_q  <= 1'b0;
            aluctrl_q <= '0;
            regwr_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (Stall) begin
            if (refresh_a) begin
                rega_q <= MemWbBusW;
            end
            if (refresh_b) begin
                regb_q <= MemWbBusW;
            end
        end else begin
            rega_q    <= RegA;
            regb_q    <= RegB;
            imm_q     <= Imm;
            ra_q      <= RA;
            rb_q      <= RB;
            rw_q      <= RW;
            alusrc_q  <= ALUSrc;
            aluctrl_q <= ALUCtrlIn;
            regwr_q   <= RegWrIn;
            valid_q   <= InValid;
        end
    end

    operand_forward_mux #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_fwd_a (
        .src        (ra_q),
        .reg_val    (rega_q),
        .exmem_wr   (ExMemRegWr),
        .exmem_rw   (ExMemRW),
        .exmem_busw (ExMemBusW),
        .memwb_wr   (MemWbRegWr),
        .memwb_rw   (MemWbRW),
        .memwb_busw (MemWbBusW),
        .fwd        (fwd_a)
    );

    operand_forward_mux #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_fwd_b (
        .src        (rb_q),
        .reg_val    (regb_q),
        .exmem_wr   (ExMemRegWr),
        .exmem_rw   (ExMemRW),
        .exmem_busw (ExMemBusW),
        .memwb_wr   (MemWbRegWr),
        .memwb_rw   (MemWbRW),
        .memwb_busw (MemWbBusW),
        .fwd        (fwd_b)
    );

    // Stores need the forwarded RB even when the ALU is fed the immediate
    assign BusA      = fwd_a;
    assign BusB      = alusrc_q ? imm_q : fwd_b;
    assign StoreData = fwd_b;
    assign ALUCtrl   = aluctrl_q;
    assign RWOut     = rw_q;
    assign OutValid  = valid_q;
    assign RegWrOut  = regwr_q & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: hand-computed vector table, corner sequences,
// then random traffic compared against a behavioural model of the stage.
module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        inval;
        logic [63:0] rega;
        logic [63:0] regb;
        logic [63:0] imm;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic        alusrc;
        logic [3:0]  ctrl;
        logic        regwr;
        logic        exw;
        logic [4:0]  exrw;
        logic [63:0] exbus;
        logic        mww;
        logic [4:0]  mwrw;
        logic [63:0] mwbus;
    } vin_t;

    typedef struct packed {
        logic [63:0] busa;
        logic [63:0] busb;
        logic [3:0]  ctrl;
        logic [63:0] store;
        logic [4:0]  rw;
        logic        regwr;
        logic        valid;
    } vout_t;

    typedef struct packed {
        vin_t  in;
        vout_t exp;
    } vec_t;

    // The instruction currently held in the stage, as the model sees it
    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic        alusrc;
        logic [3:0]  ctrl;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [63:0] rega;
        logic [63:0] regb;
        logic [63:0] imm;
    } inst_t;

    logic  Clk = 1'b0;
    logic  ResetL;
    vin_t  cur;
    inst_t held;
    int    n_vec = 0;
    int    n_err = 0;

    logic [63:0] BusA, BusB, StoreData;
    logic [3:0]  ALUCtrl;
    logic [4:0]  RWOut;
    logic        RegWrOut, OutValid;

    always #5 Clk = ~Clk;

    id_ex_operand_stage dut (
        .Clk        (Clk),
        .ResetL     (ResetL),
        .Stall      (cur.stall),
        .Flush      (cur.flush),
        .InValid    (cur.inval),
        .RegA       (cur.rega),
        .RegB       (cur.regb),
        .Imm        (cur.imm),
        .RA         (cur.ra),
        .RB         (cur.rb),
        .RW         (cur.rw),
        .ALUSrc     (cur.alusrc),
        .ALUCtrlIn  (cur.ctrl),
        .RegWrIn    (cur.regwr),
        .ExMemRegWr (cur.exw),
        .ExMemRW    (cur.exrw),
        .ExMemBusW  (cur.exbus),
        .MemWbRegWr (cur.mww),
        .MemWbRW    (cur.mwrw),
        .MemWbBusW  (cur.mwbus),
        .BusA       (BusA),
        .BusB       (BusB),
        .ALUCtrl    (ALUCtrl),
        .StoreData  (StoreData),
        .RWOut      (RWOut),
        .RegWrOut   (RegWrOut),
        .OutValid   (OutValid)
    );

    function automatic vin_t cap(logic [4:0] ra, logic [4:0] rb, logic [4:0] rw,
                                 logic [63:0] rega, logic [63:0] regb, logic [63:0] imm,
                                 logic alusrc, logic [3:0] ctrl, logic regwr, logic valid);
        vin_t v;
        v        = '0;
        v.ra     = ra;
        v.rb     = rb;
        v.rw     = rw;
        v.rega   = rega;
        v.regb   = regb;
        v.imm    = imm;
        v.alusrc = alusrc;
        v.ctrl   = ctrl;
        v.regwr  = regwr;
        v.inval  = valid;
        return v;
    endfunction

    function automatic vout_t mko(logic [63:0] busa, logic [63:0] busb, logic [3:0] ctrl,
                                  logic [63:0] store, logic [4:0] rw, logic regwr, logic valid);
        vout_t o;
        o.busa  = busa;
        o.busb  = busb;
        o.ctrl  = ctrl;
        o.store = store;
        o.rw    = rw;
        o.regwr = regwr;
        o.valid = valid;
        return o;
    endfunction

    // Youngest in-flight producer of a register supplies its value; X31 is hard zero-ish
    function automatic logic [63:0] operand(logic [4:0] src, logic [63:0] latched, vin_t v);
        logic        wr  [2];
        logic [4:0]  dst [2];
        logic [63:0] val [2];
        wr[0] = v.exw; dst[0] = v.exrw; val[0] = v.exbus;
        wr[1] = v.mww; dst[1] = v.mwrw; val[1] = v.mwbus;
        if (src == 5'd31) return latched;
        for (int i = 0; i < 2; i++) begin
            if (wr[i] && dst[i] == src) return val[i];
        end
        return latched;
    endfunction

    function automatic vout_t model_out(vin_t v);
        logic [63:0] a, b;
        a = operand(held.ra, held.rega, v);
        b = operand(held.rb, held.regb, v);
        return mko(a, held.alusrc ? held.imm : b, held.ctrl, b, held.rw,
                   held.regwr && held.valid, held.valid);
    endfunction

    function automatic void model_edge(vin_t v);
        if (v.flush) begin
            held = '0;
        end else if (v.stall) begin
            if (v.mww && v.mwrw != 5'd31 && v.mwrw == held.ra) held.rega = v.mwbus;
            if (v.mww && v.mwrw != 5'd31 && v.mwrw == held.rb) held.regb = v.mwbus;
        end else begin
            held.valid  = v.inval;
            held.regwr  = v.regwr;
            held.alusrc = v.alusrc;
            held.ctrl   = v.ctrl;
            held.ra     = v.ra;
            held.rb     = v.rb;
            held.rw     = v.rw;
            held.rega   = v.rega;
            held.regb   = v.regb;
            held.imm    = v.imm;
        end
    endfunction

    task automatic step(input vin_t v);
        @(negedge Clk);
        cur = v;
        @(posedge Clk);
        if (ResetL) model_edge(v);
        #1;
    endtask

    task automatic check(input string name, input vout_t exp);
        vout_t got;
        got = mko(BusA, BusB, ALUCtrl, StoreData, RWOut, RegWrOut, OutValid);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got busa=%h busb=%h ctrl=%h store=%h rw=%0d regwr=%b valid=%b, want busa=%h busb=%h ctrl=%h store=%h rw=%0d regwr=%b valid=%b",
                     name, got.busa, got.busb, got.ctrl, got.store, got.rw, got.regwr, got.valid,
                     exp.busa, exp.busb, exp.ctrl, exp.store, exp.rw, exp.regwr, exp.valid);
        end
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    vec_t tbl [8];

    initial begin
        vin_t v;

        v = cap(1, 2, 3, 64'd5, 64'd7, 64'd0, 0, 4'b0010, 1, 1);
        tbl[0] = '{v, mko(64'd5, 64'd7, 4'b0010, 64'd7, 3, 1, 1)};

        v = cap(4, 5, 6, 64'd1, 64'd9, 64'hFFFF_FFFF_FFFF_FFF0, 1, 4'b0000, 0, 1);
        tbl[1] = '{v, mko(64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0000, 64'd9, 6, 0, 1)};

        v = cap(3, 8, 7, 64'h100, 64'h200, 64'd0, 0, 4'b0110, 1, 1);
        v.exw = 1; v.exrw = 3; v.exbus = 64'h11;
        v.mww = 1; v.mwrw = 3; v.mwbus = 64'h22;
        tbl[2] = '{v, mko(64'h11, 64'h200, 4'b0110, 64'h200, 7, 1, 1)};

        // Stalled: new inputs ignored, RA_q=3 refreshed from MEM/WB
        v = cap(9, 9, 9, 64'hDEAD, 64'hBEEF, 64'h1, 1, 4'b0001, 0, 0);
        v.stall = 1; v.mww = 1; v.mwrw = 3; v.mwbus = 64'h22;
        tbl[3] = '{v, mko(64'h22, 64'h200, 4'b0110, 64'h200, 7, 1, 1)};

        v = cap(31, 31, 9, 64'd0, 64'h55, 64'd0, 0, 4'b0001, 1, 1);
        v.exw = 1; v.exrw = 31; v.exbus = 64'hAA;
        v.mww = 1; v.mwrw = 31; v.mwbus = 64'hBB;
        tbl[4] = '{v, mko(64'd0, 64'h55, 4'b0001, 64'h55, 9, 1, 1)};

        v = cap(5, 5, 5, 64'h77, 64'h66, 64'h3, 1, 4'b0010, 1, 1);
        v.stall = 1; v.flush = 1;
        tbl[5] = '{v, mko(64'd0, 64'd0, 4'b0000, 64'd0, 0, 0, 0)};

        v = cap(10, 11, 2, 64'h123, 64'h456, 64'd0, 0, 4'b0111, 1, 0);
        tbl[6] = '{v, mko(64'h123, 64'h456, 4'b0111, 64'h456, 2, 0, 0)};

        v = cap(12, 13, 4, 64'h2, 64'h1, 64'h5, 1, 4'b0011, 1, 1);
        v.exw = 1; v.exrw = 14; v.exbus = 64'h77;
        v.mww = 1; v.mwrw = 13; v.mwbus = 64'h31;
        tbl[7] = '{v, mko(64'h2, 64'h5, 4'b0011, 64'h31, 4, 1, 1)};

        cur    = '0;
        held   = '0;
        ResetL = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", mko(0, 0, 0, 0, 0, 0, 0));
        @(negedge Clk);
        ResetL = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].in);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Value retiring during a stall must survive after MEM/WB moves on
        step(cap(4, 6, 9, 64'd1, 64'd3, 64'd0, 0, 4'b0010, 1, 1));
        check("refresh_setup", mko(64'd1, 64'd3, 4'b0010, 64'd3, 9, 1, 1));
        v = cap(0, 0, 0, 64'h999, 64'h888, 64'd0, 0, 4'b0000, 0, 0);
        v.stall = 1; v.mww = 1; v.mwrw = 4; v.mwbus = 64'h40;
        step(v);
        check("refresh_pulse", mko(64'h40, 64'd3, 4'b0010, 64'd3, 9, 1, 1));
        v.mww = 0; v.mwbus = 64'd0;
        step(v);
        check("refresh_held", mko(64'h40, 64'd3, 4'b0010, 64'd3, 9, 1, 1));

        // Forward priority, then EX/MEM dropped
        v = cap(3, 2, 1, 64'h5, 64'h6, 64'd0, 0, 4'b0010, 1, 1);
        v.exw = 1; v.exrw = 3; v.exbus = 64'h11;
        v.mww = 1; v.mwrw = 3; v.mwbus = 64'h22;
        step(v);
        check("prio_both", mko(64'h11, 64'h6, 4'b0010, 64'h6, 1, 1, 1));
        @(negedge Clk);
        cur.exw = 0;
        #1;
        check("prio_memwb", mko(64'h22, 64'h6, 4'b0010, 64'h6, 1, 1, 1));
        cur.stall = 1;
        @(posedge Clk);
        model_edge(cur);
        #1;

        // Asynchronous reset in the middle of a stall, away from any clock edge
        @(negedge Clk);
        cur = '0;
        cur.stall = 1;
        #2;
        ResetL = 1'b0;
        #1;
        held = '0;
        check("reset_mid_stall", mko(0, 0, 0, 0, 0, 0, 0));
        @(negedge Clk);
        ResetL = 1'b1;

        for (int i = 0; i < 400; i++) begin
            v.stall  = ($urandom_range(0, 4) == 0);
            v.flush  = ($urandom_range(0, 9) == 0);
            v.inval  = $urandom_range(0, 1);
            v.rega   = {$urandom, $urandom};
            v.regb   = {$urandom, $urandom};
            v.imm    = {$urandom, $urandom};
            v.ra     = rnd_reg();
            v.rb     = rnd_reg();
            v.rw     = rnd_reg();
            v.alusrc = $urandom_range(0, 1);
            v.ctrl   = 4'($urandom_range(0, 15));
            v.regwr  = $urandom_range(0, 1);
            v.exw    = $urandom_range(0, 1);
            v.exrw   = rnd_reg();
            v.exbus  = {$urandom, $urandom};
            v.mww    = $urandom_range(0, 1);
            v.mwrw   = rnd_reg();
            v.mwbus  = {$urandom, $urandom};
            step(v);
            check($sformatf("random[%0d]", i), model_out(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
